// File: rtl/hermes_periph_mux.sv
// hermes_periph_mux: shares one Hermes PE port among N_CH peripheral channels (round-robin egress, address-decoded ingress).
// Define HERMES_PERIPH_MUX_RELEASE_EN to gate every outgoing valid with release_i.
module hermes_periph_mux #(
  parameter int N_CH = 2,
  parameter int FLIT_SIZE = 32,
  parameter logic [N_CH-1:0][15:0] CH_ADDR = {16'h0100, 16'h0000}
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [N_CH-1:0]                ch_rx_i,
  output logic [N_CH-1:0]                ch_credit_o,
  input  logic [N_CH-1:0][FLIT_SIZE-1:0] ch_data_i,
  output logic [N_CH-1:0]                ch_tx_o,
  input  logic [N_CH-1:0]                ch_credit_i,
  output logic [FLIT_SIZE-1:0]           ch_data_o,
  output logic                           noc_tx_o,
  input  logic                           noc_credit_i,
  output logic [FLIT_SIZE-1:0]           noc_data_o,
  input  logic                           noc_rx_i,
  output logic                           noc_credit_o,
  input  logic [FLIT_SIZE-1:0]           noc_data_i,
  input  logic                           release_i,
  output logic [15:0]                    drop_cnt_o
);
  localparam int GW = $clog2(N_CH);
  typedef enum logic [1:0] {E_IDLE, E_HEADER, E_SIZE, E_PAYLOAD} eg_t;
  typedef enum logic [2:0] {I_IDLE, I_SIZE, I_PAYLOAD, I_DROP_SIZE, I_DROP} in_t;
  logic rel;
`ifdef HERMES_PERIPH_MUX_RELEASE_EN
  assign rel = release_i;
`else
  logic unused_release;
  assign rel = 1'b1;
  assign unused_release = release_i;
`endif
  eg_t eg_q, eg_d;
  logic [GW-1:0] g_q, g_d, rr_q, rr_d, pick, g_nxt;
  logic [31:0] ecnt_q, ecnt_d, e_n;
  logic e_act, e_fire;
  always_comb begin
    pick = rr_q;
    for (int k = N_CH - 1; k >= 0; k--)
      if (ch_rx_i[(int'(rr_q) + k) % N_CH]) pick = GW'((int'(rr_q) + k) % N_CH);
  end
  assign e_act = eg_q != E_IDLE;
  assign noc_tx_o = e_act & ch_rx_i[g_q] & rel;
  assign noc_data_o = e_act ? ch_data_i[g_q] : '0;
  assign e_fire = noc_tx_o & noc_credit_i;
  assign e_n = 32'(ch_data_i[g_q]);
  assign g_nxt = (g_q == GW'(N_CH - 1)) ? '0 : g_q + 1'b1;
  always_comb begin
    ch_credit_o = '0;
    if (e_act) ch_credit_o[g_q] = noc_credit_i;
  end
  always_comb begin
    eg_d = eg_q;
    g_d = g_q;
    rr_d = rr_q;
    ecnt_d = ecnt_q;
    case (eg_q)
      E_IDLE: if (|ch_rx_i) begin
        g_d = pick;
        eg_d = E_HEADER;
      end
      E_HEADER: if (e_fire) eg_d = E_SIZE;
      E_SIZE: if (e_fire) begin
        ecnt_d = e_n;
        eg_d = (e_n == 32'd0) ? E_IDLE : E_PAYLOAD;
        rr_d = (e_n == 32'd0) ? g_nxt : rr_q;
      end
      E_PAYLOAD: if (e_fire) begin
        ecnt_d = ecnt_q - 32'd1;
        eg_d = (ecnt_q == 32'd1) ? E_IDLE : E_PAYLOAD;
        rr_d = (ecnt_q == 32'd1) ? g_nxt : rr_q;
      end
      default: eg_d = E_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      eg_q <= E_IDLE;
      g_q <= '0;
      rr_q <= '0;
      ecnt_q <= '0;
    end else begin
      eg_q <= eg_d;
      g_q <= g_d;
      rr_q <= rr_d;
      ecnt_q <= ecnt_d;
    end
  in_t in_q, in_d;
  logic [GW-1:0] s_q, s_d, hsel, cur;
  logic [31:0] icnt_q, icnt_d, i_n;
  logic [15:0] drop_q, drop_d;
  logic en_q, hit, fwd, drp, i_fire;
  // en_q keeps the combinational ingress paths quiet while reset is asserted
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) en_q <= 1'b0;
    else en_q <= 1'b1;
  always_comb begin
    hit = 1'b0;
    hsel = '0;
    for (int i = N_CH - 1; i >= 0; i--)
      if (noc_data_i[15:0] == CH_ADDR[i]) begin
        hit = 1'b1;
        hsel = GW'(i);
      end
  end
  assign cur = (in_q == I_IDLE) ? hsel : s_q;
  assign fwd = en_q & ((in_q == I_IDLE & hit) | in_q == I_SIZE | in_q == I_PAYLOAD);
  assign drp = en_q & ((in_q == I_IDLE & !hit) | in_q == I_DROP_SIZE | in_q == I_DROP);
  assign noc_credit_o = drp | (fwd & ch_credit_i[cur]);
  assign ch_data_o = en_q ? noc_data_i : '0;
  assign i_fire = noc_rx_i & noc_credit_o;
  assign i_n = 32'(noc_data_i);
  assign drop_cnt_o = drop_q;
  always_comb begin
    ch_tx_o = '0;
    if (fwd) ch_tx_o[cur] = noc_rx_i & rel;
  end
  always_comb begin
    in_d = in_q;
    s_d = s_q;
    icnt_d = icnt_q;
    drop_d = drop_q;
    case (in_q)
      I_IDLE: if (i_fire) begin
        s_d = hsel;
        in_d = hit ? I_SIZE : I_DROP_SIZE;
        drop_d = (!hit && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
      end
      I_SIZE, I_DROP_SIZE: if (i_fire) begin
        icnt_d = i_n;
        in_d = (i_n == 32'd0) ? I_IDLE : (in_q == I_SIZE ? I_PAYLOAD : I_DROP);
      end
      I_PAYLOAD, I_DROP: if (i_fire) begin
        icnt_d = icnt_q - 32'd1;
        in_d = (icnt_q == 32'd1) ? I_IDLE : in_q;
      end
      default: in_d = I_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      in_q <= I_IDLE;
      s_q <= '0;
      icnt_q <= '0;
      drop_q <= '0;
    end else begin
      in_q <= in_d;
      s_q <= s_d;
      icnt_q <= icnt_d;
      drop_q <= drop_d;
    end
endmodule

// File: tb/tb_hermes_periph_mux.sv
// tb_hermes_periph_mux: scoreboard bench; stimulus pushes expected flits, a monitor pops them on every DUT transfer.
module tb_hermes_periph_mux;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_ni, noc_tx_o, noc_credit_i, noc_rx_i, noc_credit_o, release_i;
  logic [1:0] ch_rx_i, ch_credit_o, ch_tx_o, ch_credit_i, tx_seen;
  logic [1:0][31:0] ch_data_i;
  logic [31:0] ch_data_o, noc_data_o, noc_data_i;
  logic [15:0] drop_cnt_o;
  logic [31:0] txq0[$], txq1[$], inq[$], exp_eg[$];
  logic [32:0] exp_in[$];
  int checks = 0, errors = 0, eg_pops = 0, in_fires = 0;

  hermes_periph_mux dut (
    .clk_i(clk), .rst_ni(rst_ni), .ch_rx_i(ch_rx_i), .ch_credit_o(ch_credit_o),
    .ch_data_i(ch_data_i), .ch_tx_o(ch_tx_o), .ch_credit_i(ch_credit_i), .ch_data_o(ch_data_o),
    .noc_tx_o(noc_tx_o), .noc_credit_i(noc_credit_i), .noc_data_o(noc_data_o),
    .noc_rx_i(noc_rx_i), .noc_credit_o(noc_credit_o), .noc_data_i(noc_data_i),
    .release_i(release_i), .drop_cnt_o(drop_cnt_o)
  );

  // peripherals and NoC source: present queue heads, pop on accepted transfers
  initial forever begin
    @(negedge clk);
    ch_rx_i[0] = txq0.size() > 0;
    ch_data_i[0] = ch_rx_i[0] ? txq0[0] : 32'h0;
    ch_rx_i[1] = txq1.size() > 0;
    ch_data_i[1] = ch_rx_i[1] ? txq1[0] : 32'h0;
    noc_rx_i = inq.size() > 0;
    noc_data_i = noc_rx_i ? inq[0] : 32'h0;
    #2;
    if (ch_rx_i[0] && ch_credit_o[0] && txq0.size() > 0) void'(txq0.pop_front());
    if (ch_rx_i[1] && ch_credit_o[1] && txq1.size() > 0) void'(txq1.pop_front());
    if (noc_rx_i && noc_credit_o && inq.size() > 0) begin
      void'(inq.pop_front());
      in_fires++;
    end
  end

  initial begin
    logic [31:0] e;
    logic [32:0] ei;
    forever begin
      @(negedge clk);
      #2;
      tx_seen = tx_seen | ch_tx_o;
      if (noc_tx_o && noc_credit_i) begin
        checks++;
        eg_pops++;
        if (exp_eg.size() == 0) begin
          errors++;
          $display("FAIL egress_unexpected got %h", noc_data_o);
        end else begin
          e = exp_eg.pop_front();
          if (noc_data_o !== e) begin
            errors++;
            $display("FAIL egress_flit got %h exp %h", noc_data_o, e);
          end
        end
      end
      for (int c = 0; c < 2; c++)
        if (ch_tx_o[c] && ch_credit_i[c]) begin
          checks++;
          if (exp_in.size() == 0) begin
            errors++;
            $display("FAIL ingress_unexpected ch %0d got %h", c, ch_data_o);
          end else begin
            ei = exp_in.pop_front();
            if ({c[0], ch_data_o} !== ei) begin
              errors++;
              $display("FAIL ingress_flit got ch %0d %h exp ch %0d %h", c, ch_data_o, ei[32], ei[31:0]);
            end
          end
        end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  task automatic send_eg(input int c, input logic [31:0] hdr, input int n, input int np, input logic [31:0] base);
    logic [31:0] f[$];
    f.push_back(hdr);
    f.push_back(32'(n));
    for (int i = 0; i < np; i++) f.push_back(base + 32'(i));
    foreach (f[i]) begin
      if (c == 0) txq0.push_back(f[i]);
      else txq1.push_back(f[i]);
      exp_eg.push_back(f[i]);
    end
  endtask

  task automatic send_in(input logic [31:0] hdr, input int n, input int np, input logic [31:0] base,
                         input logic ch, input logic fwd);
    logic [31:0] f[$];
    f.push_back(hdr);
    f.push_back(32'(n));
    for (int i = 0; i < np; i++) f.push_back(base + 32'(i));
    foreach (f[i]) begin
      inq.push_back(f[i]);
      if (fwd) exp_in.push_back({ch, f[i]});
    end
  endtask

  function automatic int pending();
    return txq0.size() + txq1.size() + inq.size() + exp_eg.size() + exp_in.size();
  endfunction

  task automatic drain(input string name, input int bound);
    int k = 0;
    while (pending() != 0 && k < bound) begin
      @(negedge clk);
      #4;
      k++;
    end
    checks++;
    if (pending() != 0) begin
      errors++;
      $display("FAIL %s drain_timeout left_eg %0d left_in %0d", name, exp_eg.size(), exp_in.size());
      txq0.delete(); txq1.delete(); inq.delete(); exp_eg.delete(); exp_in.delete();
    end
    @(negedge clk);
    #1;
  endtask

  initial begin
    int n0, cnt;
    rst_ni = 1'b0;
    noc_credit_i = 1'b1;
    ch_credit_i = 2'b11;
    tx_seen = 2'b00;
`ifdef HERMES_PERIPH_MUX_RELEASE_EN
    release_i = 1'b1;
`else
    release_i = 1'b0;
`endif
    repeat (2) @(negedge clk);
    #1;
    chk("rst_noc_tx", 32'(noc_tx_o), 0);
    chk("rst_ch_credit", 32'(ch_credit_o), 0);
    chk("rst_noc_credit", 32'(noc_credit_o), 0);
    chk("rst_drop_cnt", 32'(drop_cnt_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    @(negedge clk);
    #1;
    // simultaneous requests after reset: ch0 first, then ch1
    send_eg(0, 32'h0000_0000, 3, 3, 32'hA000_0000);
    send_eg(1, 32'h0000_0200, 2, 2, 32'hB000_0000);
    drain("rr_pair", 100);
    // ch0 alone moves rr to 1, so the next tie goes to ch1
    send_eg(0, 32'h0000_0011, 1, 1, 32'hC000_0000);
    drain("ch0_alone", 50);
    send_eg(1, 32'h0000_0022, 1, 1, 32'hC100_0000);
    send_eg(0, 32'h0000_0033, 1, 1, 32'hC200_0000);
    drain("rr_rotate", 100);
    // zero-length packet under a toggling NoC credit
    n0 = eg_pops;
    cnt = 0;
    send_eg(1, 32'h0000_0300, 0, 0, 32'h0);
    repeat (12) begin
      @(negedge clk);
      noc_credit_i = ~noc_credit_i;
      #3;
      if (ch_credit_o[0]) cnt++;
    end
    noc_credit_i = 1'b1;
    chk("ch0_credit_low", 32'(cnt), 0);
    drain("n0_packet", 50);
    chk("n0_flit_count", 32'(eg_pops - n0), 2);
    chk("eg_idle_credit", 32'(ch_credit_o), 0);
    // ingress to ch1 (address 0x0100) with its credit stalled
    ch_credit_i[1] = 1'b0;
    send_in(32'h0000_0100, 2, 2, 32'hD000_0000, 1'b1, 1'b1);
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      #3;
      if (noc_rx_i && !noc_credit_o && ch_tx_o[1]) cnt++;
    end
    chk("in_stall_cycles", 32'(cnt), 5);
    chk("in_stall_nothing_out", 32'(exp_in.size()), 4);
    @(negedge clk);
    ch_credit_i[1] = 1'b1;
    drain("in_ch1", 50);
    send_in(32'h0000_0000, 1, 1, 32'hE000_0000, 1'b0, 1'b1);
    drain("in_ch0", 50);
    // unmatched header is swallowed regardless of channel credits
    ch_credit_i = 2'b00;
    tx_seen = 2'b00;
    n0 = in_fires;
    send_in(32'h0000_0305, 4, 4, 32'hF000_0000, 1'b0, 1'b0);
    drain("drop", 50);
    chk("drop_flits", 32'(in_fires - n0), 6);
    chk("drop_no_tx", 32'(tx_seen), 0);
    chk("drop_cnt", 32'(drop_cnt_o), 1);
    ch_credit_i = 2'b11;
    // egress and ingress in parallel
    send_eg(1, 32'h0000_0044, 2, 2, 32'h1100_0000);
    send_in(32'h0000_0000, 2, 2, 32'h2200_0000, 1'b0, 1'b1);
    drain("concurrent", 60);
    // both paths parked in PAYLOAD with count 2, then reset
    send_eg(0, 32'h0000_0400, 4, 2, 32'h5000_0000);
    send_in(32'h0000_0000, 4, 2, 32'h6000_0000, 1'b0, 1'b1);
    drain("pre_reset", 60);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_noc_tx", 32'(noc_tx_o), 0);
    chk("mid_rst_ch_credit", 32'(ch_credit_o), 0);
    chk("mid_rst_noc_credit", 32'(noc_credit_o), 0);
    chk("mid_rst_ch_tx", 32'(ch_tx_o), 0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt_o), 0);
    @(negedge clk);
    rst_ni = 1'b1;
    #1;
    send_in(32'h0000_0100, 1, 1, 32'h7000_0000, 1'b1, 1'b1);
    send_eg(1, 32'h0000_0500, 1, 1, 32'h8000_0000);
    drain("post_reset", 60);
`ifdef HERMES_PERIPH_MUX_RELEASE_EN
    release_i = 1'b0;
    send_eg(0, 32'h0000_0600, 1, 1, 32'h9000_0000);
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      #3;
      if (noc_tx_o) cnt++;
    end
    chk("release_gate", 32'(cnt), 0);
    release_i = 1'b1;
    drain("release_resume", 50);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
